// File: rtl/decode_pkg.sv
// Shared opcodes, register-usage record and head decode for the issue buffer.
package decode_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       write_rd;
  } reg_use_t;

  // Which architectural registers an instruction reads and writes.
  // A write to x0 is discarded, so it never counts as a write.
  function automatic reg_use_t decode_use(input logic [31:0] instr);
    reg_use_t u;
    logic     writes;
    u.rs1     = instr[19:15];
    u.rs2     = instr[24:20];
    u.rd      = instr[11:7];
    u.use_rs1 = 1'b0;
    u.use_rs2 = 1'b0;
    writes    = 1'b0;
    case (instr[6:0])
      OPC_OP, OPC_OP_32:            begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; writes = 1'b1; end
      OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_LOAD, OPC_JALR:           begin u.use_rs1 = 1'b1; writes = 1'b1; end
      OPC_STORE, OPC_BRANCH:        begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL:  writes = 1'b1;
      default:                      ;
    endcase
    u.write_rd = writes && (instr[11:7] != 5'd0);
    return u;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy tracking: blocks the queue head on RAW/WAW hazards
// until writeback retires the outstanding write.
module issue_scoreboard
  import decode_pkg::*;
#(
  parameter int REGISTER_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  reg_use_t                 head_use,
  input  logic                     issue_fire,
  input  logic                     rf_writeback_enable,
  input  logic [REGISTER_SIZE-1:0] rf_writeback_addr,
  output logic                     blocked
);

  localparam int NREG = 2 ** REGISTER_SIZE;

  logic [NREG-1:0]          busy_reg;
  logic [NREG-1:0]          busy_next;
  logic [NREG-1:0]          eff_busy;
  logic [REGISTER_SIZE-1:0] rs1_idx;
  logic [REGISTER_SIZE-1:0] rs2_idx;
  logic [REGISTER_SIZE-1:0] rd_idx;

  assign rs1_idx = REGISTER_SIZE'(head_use.rs1);
  assign rs2_idx = REGISTER_SIZE'(head_use.rs2);
  assign rd_idx  = REGISTER_SIZE'(head_use.rd);

  // A same-cycle writeback frees the register (register file writes through);
  // a same-cycle issue re-sets it, so set wins over clear.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign eff_busy[gi]  = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        logic wb_hit;
        logic set_hit;
        assign wb_hit        = rf_writeback_enable && (rf_writeback_addr == REGISTER_SIZE'(gi));
        assign set_hit       = issue_fire && head_use.write_rd && (rd_idx == REGISTER_SIZE'(gi));
        assign eff_busy[gi]  = busy_reg[gi] && !wb_hit;
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !wb_hit);
      end
    end
  endgenerate

  assign blocked = (head_use.use_rs1  && eff_busy[rs1_idx]) ||
                   (head_use.use_rs2  && eff_busy[rs2_idx]) ||
                   (head_use.write_rd && eff_busy[rd_idx]);

  // Busy vector register; flush leaves it alone since issued writes still retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// Fetch-to-decode instruction queue with valid/ready handshakes and
// scoreboard-gated issue of the queue head.
module decode_issue_buffer
  import decode_pkg::*;
#(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int REGISTER_SIZE      = 5,
  parameter int QUEUE_DEPTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_valid,
  output logic                              fetch_ready,
  input  logic [INSTRUCTION_LENGTH-1:0]     fetch_instr,
  input  logic [XLEN-1:0]                   fetch_pc,
  input  logic                              flush,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [INSTRUCTION_LENGTH-1:0]     issue_instr,
  output logic [XLEN-1:0]                   issue_pc,
  output logic [REGISTER_SIZE-1:0]          issue_rd,
  output logic                              issue_rd_write,
  input  logic                              rf_writeback_enable,
  input  logic [REGISTER_SIZE-1:0]          rf_writeback_addr,
  output logic                              hazard_stall,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]  queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  logic [INSTRUCTION_LENGTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0]               pc_mem    [QUEUE_DEPTH];
  logic [PW-1:0]                 wr_ptr_reg;
  logic [PW-1:0]                 rd_ptr_reg;
  logic [CW-1:0]                 count_reg;

  logic     not_empty;
  logic     push_fire;
  logic     issue_fire;
  logic     blocked;
  reg_use_t head_use;

  assign not_empty   = (count_reg != '0);
  assign fetch_ready = (count_reg != CW'(QUEUE_DEPTH));
  assign push_fire   = fetch_valid && fetch_ready && !flush;
  assign issue_valid = not_empty && !blocked && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign hazard_stall = not_empty && blocked;
  assign queue_count = count_reg;

  assign issue_instr    = instr_mem[rd_ptr_reg];
  assign issue_pc       = pc_mem[rd_ptr_reg];
  assign head_use       = decode_use(issue_instr[31:0]);
  assign issue_rd       = REGISTER_SIZE'(head_use.rd);
  assign issue_rd_write = head_use.write_rd;

  // Entry storage: each slot captures fetch data when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          instr_mem[gi] <= '0;
          pc_mem[gi]    <= '0;
        end else if (push_fire && (wr_ptr_reg == PW'(gi))) begin
          instr_mem[gi] <= fetch_instr;
          pc_mem[gi]    <= fetch_pc;
        end
      end
    end
  endgenerate

  // Pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (issue_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_fire && !issue_fire)      count_reg <= count_reg + 1'b1;
      else if (!push_fire && issue_fire) count_reg <= count_reg - 1'b1;
    end
  end

  issue_scoreboard #(
    .REGISTER_SIZE (REGISTER_SIZE)
  ) u_scoreboard (
    .clk                 (clk),
    .rst                 (rst),
    .head_use            (head_use),
    .issue_fire          (issue_fire),
    .rf_writeback_enable (rf_writeback_enable),
    .rf_writeback_addr   (rf_writeback_addr),
    .blocked             (blocked)
  );

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Scoreboard bench: expected issues are queued at push time and compared
// when the DUT hands the head to decode.
module tb_decode_issue_buffer;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        rd_write;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_instr = '0;
  logic [63:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] issue_instr;
  logic [63:0] issue_pc;
  logic [4:0]  issue_rd;
  logic        issue_rd_write;
  logic        rf_writeback_enable = 1'b0;
  logic [4:0]  rf_writeback_addr = '0;
  logic        hazard_stall;
  logic [2:0]  queue_count;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  decode_issue_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_instr         (fetch_instr),
    .fetch_pc            (fetch_pc),
    .flush               (flush),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_instr         (issue_instr),
    .issue_pc            (issue_pc),
    .issue_rd            (issue_rd),
    .issue_rd_write      (issue_rd_write),
    .rf_writeback_enable (rf_writeback_enable),
    .rf_writeback_addr   (rf_writeback_addr),
    .hazard_stall        (hazard_stall),
    .queue_count         (queue_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, opc};
  endfunction

  // Issue monitor: every handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_issue", 64'(issue_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("issue pc=%0h instr=%08h rd=%0d rd_write=%0b", issue_pc, issue_instr, issue_rd, issue_rd_write);
        check_val("issue_pc", issue_pc, e.pc);
        check_val("issue_instr", 64'(issue_instr), 64'(e.instr));
        check_val("issue_rd_write", 64'(issue_rd_write), 64'(e.rd_write));
        check_val("issue_rd", 64'(issue_rd), 64'(e.instr[11:7]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until it is accepted (bounded).
  task automatic push(input logic [31:0] ins, input logic [63:0] pc, input logic rdw);
    bit ok = 0;
    exp_t e;
    fetch_valid = 1'b1;
    fetch_instr = ins;
    fetch_pc    = pc;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (fetch_ready && !flush) begin
        e.pc = pc; e.instr = ins; e.rd_write = rdw;
        exp_q.push_back(e);
        ok = 1;
      end
    end
    if (!ok) check_val("push_timeout", 64'(fetch_ready), 64'd1);
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] r);
    rf_writeback_enable = 1'b1;
    rf_writeback_addr   = r;
    tick();
    rf_writeback_enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_issue_valid", 64'(issue_valid), 0);
    check_val("rst_hazard", 64'(hazard_stall), 0);
    check_val("rst_count", 64'(queue_count), 0);
    check_val("rst_fetch_ready", 64'(fetch_ready), 1);
    check_val("rst_issue_pc", issue_pc, 0);
    check_val("rst_issue_instr", 64'(issue_instr), 0);
    rst = 1'b0;
    tick();

    // Fill / drain
    issue_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push(enc_i(OP_IMM, 5'(i), 5'd0, 12'(i)), 64'h1000 + 64'(4 * i), 1'b1);
    @(negedge clk);
    check_val("full_count", 64'(queue_count), 4);
    check_val("full_fetch_ready", 64'(fetch_ready), 0);
    tick();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("drain_valid", 64'(issue_valid), 1);
      if (i == 0) check_val("full_pop_fetch_ready", 64'(fetch_ready), 0);
      tick();
    end
    @(negedge clk);
    check_val("drained_count", 64'(queue_count), 0);
    tick();
    for (int r = 1; r <= 4; r++) writeback(5'(r));

    // RAW stall on lw x5 -> add x6,x5,x1
    push(enc_i(LOAD, 5'd5, 5'd2, 12'd0), 64'h2000, 1'b1);
    push(enc_r(OP, 5'd6, 5'd5, 5'd1), 64'h2004, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("raw_stall", 64'(hazard_stall), 1);
      check_val("raw_valid", 64'(issue_valid), 0);
      tick();
    end
    rf_writeback_enable = 1'b1;
    rf_writeback_addr   = 5'd5;
    @(negedge clk);
    check_val("raw_issue_in_wb_cycle", 64'(issue_valid), 1);
    tick();
    rf_writeback_enable = 1'b0;
    writeback(5'd6);

    // WAW with same-cycle set/clear of x7
    push(enc_i(OP_IMM, 5'd7, 5'd0, 12'd1), 64'h3000, 1'b1);
    push(enc_i(OP_IMM, 5'd7, 5'd0, 12'd2), 64'h3004, 1'b1);
    @(negedge clk);
    check_val("waw_stall", 64'(hazard_stall), 1);
    tick();
    rf_writeback_enable = 1'b1;
    rf_writeback_addr   = 5'd7;
    @(negedge clk);
    check_val("waw_issue_in_wb_cycle", 64'(issue_valid), 1);
    tick();
    rf_writeback_enable = 1'b0;
    push(enc_r(OP, 5'd8, 5'd7, 5'd0), 64'h3008, 1'b1);
    @(negedge clk);
    check_val("x7_still_busy", 64'(hazard_stall), 1);
    tick();
    writeback(5'd7);
    writeback(5'd8);

    // x0 handling
    issue_ready = 1'b0;
    push(enc_i(OP_IMM, 5'd0, 5'd0, 12'd1), 64'h4000, 1'b0);
    push(enc_r(OP, 5'd1, 5'd0, 5'd0), 64'h4004, 1'b1);
    @(negedge clk);
    check_val("x0_head_rd_write", 64'(issue_rd_write), 0);
    check_val("x0_head_valid", 64'(issue_valid), 1);
    tick();
    issue_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("x0_no_stall", 64'(issue_valid), 1);
      tick();
    end
    writeback(5'd1);

    // Flush with concurrent fetch; x9 busy survives
    push(enc_i(OP_IMM, 5'd9, 5'd0, 12'd1), 64'h5000, 1'b1);
    tick();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(enc_r(OP, 5'(10 + i), 5'd0, 5'd0), 64'h5010 + 64'(4 * i), 1'b1);
    @(negedge clk);
    check_val("pre_flush_count", 64'(queue_count), 3);
    tick();
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = enc_r(OP, 5'd20, 5'd0, 5'd0);
    fetch_pc    = 64'h5FFF;
    @(negedge clk);
    check_val("flush_no_issue", 64'(issue_valid), 0);
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("post_flush_count", 64'(queue_count), 0);
    check_val("post_flush_valid", 64'(issue_valid), 0);
    tick();
    issue_ready = 1'b1;
    push(enc_r(OP, 5'd13, 5'd9, 5'd0), 64'h5100, 1'b1);
    @(negedge clk);
    check_val("x9_busy_after_flush", 64'(hazard_stall), 1);
    tick();
    rf_writeback_enable = 1'b1;
    rf_writeback_addr   = 5'd9;
    @(negedge clk);
    check_val("x9_wb_issue", 64'(issue_valid), 1);
    tick();
    rf_writeback_enable = 1'b0;
    writeback(5'd13);

    // Asynchronous reset mid-stream
    push(enc_i(OP_IMM, 5'd5, 5'd0, 12'd1), 64'h6000, 1'b1);
    tick();
    issue_ready = 1'b0;
    push(enc_r(OP, 5'd14, 5'd5, 5'd0), 64'h6004, 1'b1);
    push(enc_i(OP_IMM, 5'd15, 5'd0, 12'd1), 64'h6008, 1'b1);
    @(negedge clk);
    check_val("pre_rst_count", 64'(queue_count), 2);
    check_val("pre_rst_stall", 64'(hazard_stall), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_count", 64'(queue_count), 0);
    check_val("arst_valid", 64'(issue_valid), 0);
    check_val("arst_stall", 64'(hazard_stall), 0);
    check_val("arst_fetch_ready", 64'(fetch_ready), 1);
    check_val("arst_issue_pc", issue_pc, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    issue_ready = 1'b1;
    push(enc_r(OP, 5'd14, 5'd5, 5'd0), 64'h7000, 1'b1);
    @(negedge clk);
    check_val("x5_free_after_rst", 64'(hazard_stall), 0);
    check_val("x5_free_valid", 64'(issue_valid), 1);
    tick();
    writeback(5'd14);
    repeat (2) tick();

    check_val("exp_q_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_issue_buffer.md
# decode_issue_buffer

Parametrised front half of the decode stage. It replaces the single `f_to_d_enable_ff` / `d_to_e_enable_ff` enable pair with valid/ready handshakes and a QUEUE_DEPTH-entry instruction queue between fetch and decode. It also adds a register scoreboard that holds back RAW and WAW hazards until the writeback stage retires the producing write. It sits between the fetch stage and the decode/execute boundary, and takes flush requests from jump/branch resolution.

## Interface
Parameters:
- XLEN, 64, datapath/PC width
- INSTRUCTION_LENGTH, 32, instruction width
- REGISTER_SIZE, 5, register address width (32 architectural registers)
- QUEUE_DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous and active-high
- fetch_valid  in  1  fetch offers an instruction
- fetch_ready  out  1  queue accepts an instruction
- fetch_instr  in  INSTRUCTION_LENGTH  instruction word
- fetch_pc  in  XLEN  PC of fetch_instr
- flush  in  1  redirect: discard all queued instructions
- issue_valid  out  1  queue head is hazard-free and offered
- issue_ready  in  1  decode/execute accepts the head
- issue_instr  out  INSTRUCTION_LENGTH  head instruction
- issue_pc  out  XLEN  head PC
- issue_rd  out  REGISTER_SIZE  head destination (instr[11:7])
- issue_rd_write  out  1  head writes a non-zero rd
- rf_writeback_enable  in  1  writeback retires a register write
- rf_writeback_addr  in  REGISTER_SIZE  retired register
- hazard_stall  out  1  queue non-empty but head blocked by scoreboard
- queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries

## Operation
- **Queue.** Circular buffer with read/write pointers and a count.
  - `fetch_ready = (count != QUEUE_DEPTH)`.
  - An entry is pushed when fetch_valid & fetch_ready & !flush.
  - An entry is popped when issue_valid & issue_ready.
  - Push and pop in the same cycle leave the count unchanged; pointers wrap modulo QUEUE_DEPTH.
- **Head decode.** From opcode instr[6:0]:
  - rs1 used: OP-IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, OP-IMM-32 0011011, OP-32 0111011.
  - rs2 used: OP, STORE, BRANCH, OP-32.
  - rd written: OP-IMM, OP, LOAD, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR, OP-IMM-32, OP-32; and only when rd ≠ 0.
  - x0 is never busy.
- **Scoreboard.** One busy bit per register, x0 hard-wired 0.
  - A register is effectively busy when its busy bit is set and there is no writeback to it this cycle. A same-cycle writeback counts as free; the register file writes through.
  - Head is blocked if any used source is effectively busy (RAW), or if rd is written and effectively busy (WAW).
  - `issue_valid = (count != 0) & !blocked & !flush`.
  - `hazard_stall = (count != 0) & blocked`.
- **Busy-bit update per cycle.**
  - Cleared on writeback to that register.
  - Set on issue when issue_rd_write.
  - Simultaneous clear and set of the same register leaves the bit set.
  - A writeback to a non-busy register is ignored.
- **Flush.**
  - Count goes to 0 and pointers are reset on the next edge.
  - No issue and no scoreboard set occur in the flush cycle.
  - A fetch offered in the same cycle is dropped.
  - Busy bits are not cleared: older issued instructions still write back.

## Timing
- **Reset.** Queue empty, pointers 0, all busy bits 0, issue_valid 0, hazard_stall 0, queue_count 0, fetch_ready 1.
  - issue_instr, issue_pc and issue_rd read from storage, which resets to 0.
- **Latency.** An instruction pushed at edge N is offered with issue_valid at cycle N+1 at the earliest.
- **Throughput.** One push and one pop per cycle.
- **Full queue.** A full queue with a simultaneous pop still shows fetch_ready=0 (no same-cycle pass-through).
- **Scoreboard visibility.**
  - An instruction that issues at edge N sets busy visible from cycle N+1. The next queued consumer stalls from cycle N+1 until the writeback cycle, and issues in that cycle at the earliest.
  - The handshake is unconditional once issue_valid is asserted: the head stays stable until popped or flushed.
- **Reset mid-operation.** Asynchronous and immediate; in-flight queue contents and busy bits are lost.

## Structure
- Package `decode_pkg`:
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP_IMM_32, OPC_OP_32);
  - packed struct `reg_use_t` {rs1, rs2, rd, use_rs1, use_rs2, write_rd}.
- Sub-module `issue_scoreboard`:
  - contains the busy vector and the set/clear/blocked logic;
  - instantiated once;
  - inputs are the reg_use_t of the head, the issue fire, and writeback.
- Queue and head decode live in the top.

## Test plan
- **Fill/drain.** Push 4 independent ADDI with issue_ready=0 → queue_count=4, fetch_ready=0. Raise issue_ready → 4 issues in consecutive cycles, PCs in order.
- **RAW stall.** Issue `lw x5`, then `add x6,x5,x1` at head → hazard_stall=1, issue_valid=0. Writeback x5 in cycle K → add issues in cycle K.
- **WAW plus same-cycle set/clear.** x7 busy; at head `addi x7`; writeback x7 in the issue cycle → addi issues and x7 remains busy afterward.
- **x0 handling.** `addi x0,x0,1` followed by `add x1,x0,x0` → no stall, issue_rd_write=0 for the first.
- **Flush.** Queue count 3 with fetch_valid=1 and flush=1 → next cycle count=0, nothing issued, pending busy bits unchanged.
- **Async reset.** Assert rst mid-stream with queue count 2 and x5 busy → outputs reset immediately, x5 free after release.
